sdp_ram: RTL
============

# sdp_ram

Parametrised simple dual-port RAM with one write port (A) and one read port (B) on a single clock. It adds byte-enable writes, configurable read latency, same-address read/write forwarding, a read-valid strobe, and a hardware clear engine that zeroes the array after reset and on request. It replaces fixed-size generated dual-port memories in the datapath, such as line and tile buffers, and carries its own verified behaviour.

## Interface
- DATA_W, 16, data width in bits; must be a multiple of BYTE_W
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W
- BYTE_W, 8, bits per byte-enable lane; NBE = DATA_W/BYTE_W
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2
- BYPASS, 1, same-cycle collision policy; 1 = new data, 0 = old data

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  start a clear sweep; single-cycle pulse, sampled only while not busy
- busy  out  1  high while the clear sweep runs
- wea  in  1  write enable, port A
- addra  in  ADDR_W  write address
- dina  in  DATA_W  write data
- bea  in  NBE  byte enables; lane i covers bits [i*BYTE_W +: BYTE_W]
- reb  in  1  read enable, port B
- addrb  in  ADDR_W  read address
- doutb  out  DATA_W  read data
- doutb_valid  out  1  doutb carries the result of an accepted read

## Operation
- FSM states: CLEAR and IDLE. An address counter (ADDR_W bits) drives the sweep.
- Reset (rst_n low) forces state CLEAR, counter 0, busy 1, doutb 0, doutb_valid 0, and clears all read pipeline stages. Array contents are undefined until the sweep completes.
- CLEAR:
  - Each edge writes all-zero to mem[counter] and increments the counter.
  - On the edge that writes DEPTH-1: go to IDLE, busy falls, counter wraps to 0.
  - wea and reb are ignored; clr is ignored.
- IDLE:
  - clr=1 goes to CLEAR on the next edge with counter 0.
  - Writes and reads are accepted only in IDLE. A write or read presented on the same edge as clr is still accepted.
- Write: wea=1 updates only the lanes with bea[i]=1; other lanes keep their value. wea=1 with bea=0 is a no-op.
- Read: reb=1 is accepted and returns mem[addrb] after RD_LAT edges.
  - doutb holds its last value when no read completes.
  - doutb_valid is a one-cycle strobe per accepted read.
- Collision (wea & reb & addra==addrb on the same edge):
  - BYPASS=1: each lane returns dina where bea is set and the old contents elsewhere.
  - BYPASS=0: returns the old contents.
- A read on the edge after a write to the same address always returns the written data.
- Reads accepted before clr are already in flight and complete normally with pre-clear data.
- rst_n asserted mid-sweep or mid-read: pipeline flushed, sweep restarts at 0 after release.

## Timing
- Read accepted at edge N: doutb and doutb_valid update after edge N+RD_LAT.
  - RD_LAT=2 adds one output register stage.
- Read throughput: one read per cycle, back-to-back, in IDLE.
- Write: memory updates at the accepting edge.
- After rst_n release: busy stays high for exactly DEPTH rising edges and is low after edge DEPTH (DEPTH=16: 16 edges).
- clr sampled at edge E: busy is high after E and falls after edge E+DEPTH.
- clr has no effect while busy; it is not queued.

## Test plan
- Reset release, DEPTH=16: busy is low after the 16th edge. Reading addresses 0..15 back-to-back returns 0x0000 each, and doutb_valid is high for 16 consecutive cycles.
- Write 0xBEEF to addr 3 with bea=2'b11, then write 0x1200 with bea=2'b10 -> reading addr 3 returns 0x12EF.
- Collision on addr 5 (old 0x1111, dina 0xABCD, bea=2'b01) -> BYPASS=1 returns 0x11CD; BYPASS=0 returns 0x1111. The next-cycle read returns 0x11CD in both cases.
- RD_LAT=2 with reads issued at edges 10, 11, 12 -> doutb_valid is high after edges 12, 13, 14 with the matching data. With RD_LAT=1 it is high after edges 11, 12, 13.
- Fill all addresses with nonzero data, then pulse clr together with a read of addr 7 -> the read returns the old data. busy is high for 16 cycles, and wea/reb pulses during busy produce no write and no doutb_valid. All reads after the sweep return 0.
- Assert rst_n low at sweep address 9 and release -> the sweep restarts; busy lasts a full 16 edges; doutb is 0 and doutb_valid is 0 during reset.

Source files
------------

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port A, read port B with 1- or 2-cycle
// latency, same-address collision policy, read-valid strobe and a zeroing sweep engine.
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BYTE_W = 8,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  output logic                       busy,
  input  logic                       wea,
  input  logic [ADDR_W-1:0]          addra,
  input  logic [DATA_W-1:0]          dina,
  input  logic [DATA_W/BYTE_W-1:0]   bea,
  input  logic                       reb,
  input  logic [ADDR_W-1:0]          addrb,
  output logic [DATA_W-1:0]          doutb,
  output logic                       doutb_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NBE   = DATA_W / BYTE_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   cnt_nxt;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_word;
  logic                pipe_v;
  logic [DATA_W-1:0]   pipe_d;

  // ---------------------------------------------------------------------------
  // Sweep FSM: CLEAR walks cnt through every address, IDLE serves traffic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (&cnt) state_nxt = IDLE;
      end
      IDLE: begin
        cnt_nxt = '0;
        if (clr) state_nxt = CLEAR;
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_en = (state == IDLE) && wea;
  assign rd_en = (state == IDLE) && reb;

  // ---------------------------------------------------------------------------
  // Storage. No reset on the array; the sweep provides the defined contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NBE; i++) begin
        if (bea[i]) mem[addra][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Collision: with BYPASS the enabled lanes of the incoming write win.
  always_comb begin
    rd_word = mem[addrb];
    if ((BYPASS != 0) && wr_en && (addra == addrb)) begin
      for (int i = 0; i < NBE; i++) begin
        if (bea[i]) rd_word[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Handshake: a read is accepted on any edge where reb=1 and the
  // block is not sweeping (no ready back-pressure); doutb_valid pulses exactly
  // once, RD_LAT edges later, and doutb holds its value between completions.
  // ---------------------------------------------------------------------------
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                v_q;
      logic [DATA_W-1:0]   d_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= rd_en;
          if (rd_en) d_q <= rd_word;
        end
      end

      assign pipe_v = v_q;
      assign pipe_d = d_q;
    end else begin : g_lat1
      assign pipe_v = rd_en;
      assign pipe_d = rd_word;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutb       <= '0;
      doutb_valid <= 1'b0;
    end else begin
      doutb_valid <= pipe_v;
      if (pipe_v) doutb <= pipe_d;
    end
  end

endmodule
